lcd_text_feeder: RTL and testbench
==================================

Name: lcd_text_feeder

Overview:
- Character queue and line sequencer upstream of the LCD bus-cycle controller.
- Accepts ASCII bytes from system logic (switch/button decoders, message ROMs) and buffers them in a FIFO.
- Presents them one at a time to the controller over a valid/ready handshake, tagged with RS.
- Automatically inserts the DDRAM set-address commands needed to wrap across a 2-line display, plus clear-display commands on request.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..64.
COLS, 16, visible characters per display line.
LINE1_ADDR, 8'h80, set-DDRAM command for line 1 start.
LINE2_ADDR, 8'hC0, set-DDRAM command for line 2 start.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-low (0 = reset).
wr_en  input  1  push wr_char this cycle.
wr_char  input  8  ASCII byte; 8'h0A = newline marker.
full  output  1  FIFO full; a push while full is dropped.
clr_req  input  1  single-cycle clear pulse (e.g. from button pulse logic).
out_valid  output  1  out_data/out_rs hold a beat for the controller.
out_ready  input  1  controller accepts the beat this cycle.
out_data  output  8  byte for the LCD data bus.
out_rs  output  1  1 = character write, 0 = instruction.
busy  output  1  FIFO non-empty, beat pending, or clear pending.
ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset values (rst==0 at posedge): FIFO empty, col=0, state IDLE, out_valid=0, out_data=8'h00, out_rs=0, full=0, busy=0, ovf=0, clear_pending=0.
- FIFO: DEPTH entries with wrapping pointers and a count of width log2(DEPTH)+1.
  - full = (count==DEPTH).
  - Push and pop in the same cycle are both legal, and count is unchanged.
  - A push while full is dropped; FIFO contents are unchanged.
- Handshake:
  - A beat transfers on a posedge with out_valid && out_ready.
  - out_data and out_rs stay stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on reset.
- col counter: range 0..2*COLS-1, tracking the DDRAM position of the next character.
- FSM states: IDLE, LOAD, LINE_CMD, CHAR, CLR_CMD.
  - IDLE:
    - clear_pending → CLR_CMD.
    - Otherwise, FIFO non-empty → LOAD.
  - LOAD: peek the FIFO head.
    - head==8'h0A: pop it. Go to LINE_CMD with target = (col<COLS) ? LINE2_ADDR : LINE1_ADDR; col becomes COLS or 0 accordingly.
    - col==COLS (line 1 full, not yet wrapped): go to LINE_CMD with LINE2_ADDR; do not pop.
    - col==2*COLS: go to LINE_CMD with LINE1_ADDR, set col=0; do not pop.
    - Otherwise: pop and go to CHAR.
  - LINE_CMD: drive out_data=target, out_rs=0, out_valid=1. On transfer → IDLE.
  - CHAR: drive out_data=byte, out_rs=1, out_valid=1. On transfer: col+=1, → IDLE.
  - CLR_CMD: drive out_data=8'h01, out_rs=0, out_valid=1. On transfer: col=0, clear_pending=0, → IDLE.
- col reaches 2*COLS only transiently after the last character of line 2; the wrap to LINE1_ADDR is emitted before the next character, never spontaneously.
- Latency: push into an empty FIFO with FSM in IDLE → out_valid high 2 cycles after the push edge. Back-to-back characters with out_ready held at 1 issue one beat per 3 cycles.
- Clear:
  - clr_req flushes the FIFO immediately (count=0) and sets clear_pending.
  - A wr_en in the same cycle as clr_req is discarded.
  - Pushes after that cycle queue normally and are emitted after the 8'h01 command.
  - A beat already presented (out_valid=1) completes first; it is never aborted.
- busy = (count!=0) || out_valid || clear_pending || (state!=IDLE).
- Reset mid-beat: out_valid drops on the reset edge. The controller is reset by the same rst, so no half-transfer survives.

Optional Feature:
- Macro LCD_TEXT_FEEDER_OVF_EN.
- Defined:
  - ovf is set on any push while full (including pop-same-cycle is NOT overflow: a push while full with a simultaneous pop is accepted).
  - ovf is cleared only by reset or clr_req.
- Undefined: ovf is tied to 0; drop behaviour is unchanged.

Test Plan:
- Reset then push "PRANAV" (8'h50,52,41,4E,41,56) with out_ready=1 → six beats with out_rs=1 in order, no commands, col=6, busy falls to 0.
- Push 17 chars 'A' with out_ready=1 (DEPTH=16, push one per cycle, FSM draining) → 16 'A' beats, then out_rs=0/out_data=8'hC0, then the 17th 'A'; col=17.
- Push 32 chars then 'Z' → after the 32nd char, beat 8'h80 (rs=0), then 'Z'; col=1.
- Push 'H', 8'h0A, 'I' → beats 'H'(rs=1), 8'hC0(rs=0), 'I'(rs=1); col=COLS+1.
- Hold out_ready=0 with 'X' presented, pulse clr_req with wr_en='Y' in the same cycle, then push 'Q', then release out_ready → beats 'X', 8'h01(rs=0), 'Q'; 'Y' is never emitted; out_data stable throughout the stall.
- Fill 16 entries with out_ready=0, push 2 more → full=1, extra bytes dropped, ovf=1 with LCD_TEXT_FEEDER_OVF_EN (0 without it); clr_req → ovf=0 and FIFO empty.

Source files
------------

// File: rtl/lcd_text_feeder.sv
// Character FIFO and line sequencer feeding an LCD bus-cycle controller over valid/ready.
// Define LCD_TEXT_FEEDER_OVF_EN to enable the sticky overflow flag (ovf tied to 0 otherwise).
module lcd_text_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned COLS       = 16,
    parameter logic [7:0]  LINE1_ADDR = 8'h80,
    parameter logic [7:0]  LINE2_ADDR = 8'hC0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_char,
    output logic       full,
    input  logic       clr_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_rs,
    output logic       busy,
    output logic       ovf
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;
    localparam int unsigned CW   = $clog2(2 * COLS + 1);

    localparam logic [CntW-1:0] DepthV   = CntW'(DEPTH);
    localparam logic [CW-1:0]   ColsV    = CW'(COLS);
    localparam logic [CW-1:0]   TwoColsV = CW'(2 * COLS);
    localparam logic [7:0]      NewLine  = 8'h0A;
    localparam logic [7:0]      ClearCmd = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLineCmd,
        StChar,
        StClrCmd
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CW-1:0]   col_q, col_d;
    logic            line2_q, line2_d;
    logic            clear_pending_q;
    logic [7:0]      byte_q, byte_d;
    logic [7:0]      target_q, target_d;

    logic       push, pop, xfer, clr_done;
    logic [7:0] head;

    assign head = mem_q[rd_ptr_q];
    assign full = (count_q == DepthV);
    assign xfer = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    assign push = wr_en && !clr_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_char;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            col_q           <= '0;
            line2_q         <= 1'b0;
            clear_pending_q <= 1'b0;
            byte_q          <= 8'h00;
            target_q        <= 8'h00;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            line2_q  <= line2_d;
            byte_q   <= byte_d;
            target_q <= target_d;
            if (clr_req) begin
                clear_pending_q <= 1'b1;
            end else if (clr_done) begin
                clear_pending_q <= 1'b0;
            end
        end
    end

    // line2_q marks that LINE2_ADDR has already been issued for the current line-2 pass,
    // so reaching col==COLS does not re-issue it forever.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        line2_d  = line2_q;
        byte_d   = byte_q;
        target_d = target_q;
        pop      = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_pending_q) begin
                    state_d = StClrCmd;
                end else if (count_q != '0) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (clear_pending_q || count_q == '0) begin
                    state_d = StIdle;
                end else if (head == NewLine) begin
                    pop     = 1'b1;
                    state_d = StLineCmd;
                    if (col_q < ColsV) begin
                        target_d = LINE2_ADDR;
                        col_d    = ColsV;
                        line2_d  = 1'b1;
                    end else begin
                        target_d = LINE1_ADDR;
                        col_d    = '0;
                        line2_d  = 1'b0;
                    end
                end else if (col_q == ColsV && !line2_q) begin
                    target_d = LINE2_ADDR;
                    line2_d  = 1'b1;
                    state_d  = StLineCmd;
                end else if (col_q == TwoColsV) begin
                    target_d = LINE1_ADDR;
                    col_d    = '0;
                    line2_d  = 1'b0;
                    state_d  = StLineCmd;
                end else begin
                    pop     = 1'b1;
                    byte_d  = head;
                    state_d = StChar;
                end
            end
            StLineCmd: begin
                if (xfer) state_d = StIdle;
            end
            StChar: begin
                if (xfer) begin
                    col_d   = col_q + CW'(1);
                    state_d = StIdle;
                end
            end
            StClrCmd: begin
                if (xfer) begin
                    col_d    = '0;
                    line2_d  = 1'b0;
                    clr_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_rs    = 1'b0;
        unique case (state_q)
            StLineCmd: begin
                out_valid = 1'b1;
                out_data  = target_q;
            end
            StChar: begin
                out_valid = 1'b1;
                out_data  = byte_q;
                out_rs    = 1'b1;
            end
            StClrCmd: begin
                out_valid = 1'b1;
                out_data  = ClearCmd;
            end
            default: ;
        endcase
    end

    assign busy = (count_q != '0) || out_valid || clear_pending_q || (state_q != StIdle);

`ifdef LCD_TEXT_FEEDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst || clr_req) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed bench for lcd_text_feeder: vector table for plain text plus hand sequences for
// line wrap, newline, clear-during-stall and overflow.
module tb_lcd_text_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_char;
    logic       full;
    logic       clr_req;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_rs;
    logic       busy;
    logic       ovf;

    always #5 clk = ~clk;

    lcd_text_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_char   (wr_char),
        .full      (full),
        .clr_req   (clr_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rs    (out_rs),
        .busy      (busy),
        .ovf       (ovf)
    );

`ifdef LCD_TEXT_FEEDER_OVF_EN
    localparam logic ExpOvf = 1'b1;
`else
    localparam logic ExpOvf = 1'b0;
`endif

    typedef struct {
        logic [7:0] in_char;
        logic [7:0] exp_data;
        logic       exp_rs;
    } vec_t;

    int         nvec = 0;
    int         nerr = 0;
    int         cyc  = 0;
    logic [8:0] beats[$];
    int         beat_cyc[$];
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every transfer; sampled mid-cycle so out_ready reflects the upcoming edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            beats.push_back({out_rs, out_data});
            beat_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_char   = 8'h00;
        clr_req   = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        beats.delete();
        beat_cyc.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [7:0] c, input bit wait_room);
        int n = 0;
        while (wait_room && full && n < 500) begin
            tick;
            n++;
        end
        if (n == 500) check("push_room_timeout", 32'(n), 32'(0));
        wr_en   = 1'b1;
        wr_char = c;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 3000) begin
            tick;
            n++;
        end
        if (n == 3000) check("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic wait_valid;
        int n = 0;
        while (!out_valid && n < 100) begin
            tick;
            n++;
        end
        if (n == 100) check("valid_timeout", 32'(out_valid), 32'(1));
    endtask

    task automatic check_beats(input string name);
        check({name, "_count"}, 32'(beats.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(beats[i]), 32'(exp_q[i]));
        end
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{8'h50, 8'h50, 1'b1};
        tbl[1] = '{8'h52, 8'h52, 1'b1};
        tbl[2] = '{8'h41, 8'h41, 1'b1};
        tbl[3] = '{8'h4E, 8'h4E, 1'b1};
        tbl[4] = '{8'h41, 8'h41, 1'b1};
        tbl[5] = '{8'h56, 8'h56, 1'b1};

        // Reset state
        do_reset;
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data",  32'(out_data),  32'h00);
        check("rst_rs",    32'(out_rs),    32'(0));
        check("rst_full",  32'(full),      32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_ovf",   32'(ovf),       32'(0));

        // Latency: valid appears two edges after the push edge, then holds while stalled
        push(8'h4C, 1'b0);
        check("lat_e0_valid", 32'(out_valid), 32'(0));
        check("lat_e0_busy",  32'(busy),      32'(1));
        tick;
        check("lat_e1_valid", 32'(out_valid), 32'(0));
        tick;
        check("lat_e2_valid", 32'(out_valid), 32'(1));
        check("lat_e2_data",  32'(out_data),  32'h4C);
        check("lat_e2_rs",    32'(out_rs),    32'(1));
        for (int i = 0; i < 3; i++) begin
            tick;
            check("lat_stall_data", 32'(out_data), 32'h4C);
        end

        // PRANAV from the table, one push per cycle, controller always ready
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(tbl[i].in_char, 1'b1);
        wait_idle;
        check("pranav_count", 32'(beats.size()), 32'(6));
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            check($sformatf("pranav_data[%0d]", i), 32'(beats[i][7:0]), 32'(tbl[i].exp_data));
            check($sformatf("pranav_rs[%0d]", i),   32'(beats[i][8]),   32'(tbl[i].exp_rs));
        end
        for (int i = 1; i < 6 && i < beat_cyc.size(); i++) begin
            check($sformatf("pranav_gap[%0d]", i), 32'(beat_cyc[i] - beat_cyc[i-1]), 32'(3));
        end
        check("pranav_col",  32'(dut.col_q), 32'(6));
        check("pranav_busy", 32'(busy),      32'(0));

        // 17 chars: line 2 address inserted before the 17th
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h41, 1'b1);
        wait_idle;
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'h41});
        exp_q.push_back({1'b0, 8'hC0});
        exp_q.push_back({1'b1, 8'h41});
        check_beats("wrap2");
        check("wrap2_col", 32'(dut.col_q), 32'(17));

        // 32 chars then 'Z': wrap back to line 1 before 'Z'
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) push(8'h61 + 8'(i % 26), 1'b1);
        push(8'h5A, 1'b1);
        wait_idle;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) exp_q.push_back({1'b0, 8'hC0});
            exp_q.push_back({1'b1, 8'h61 + 8'(i % 26)});
        end
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b1, 8'h5A});
        check_beats("wrap1");
        check("wrap1_col", 32'(dut.col_q), 32'(1));

        // Newline marker
        do_reset;
        out_ready = 1'b1;
        push(8'h48, 1'b1);
        push(8'h0A, 1'b1);
        push(8'h49, 1'b1);
        wait_idle;
        exp_q.push_back({1'b1, 8'h48});
        exp_q.push_back({1'b0, 8'hC0});
        exp_q.push_back({1'b1, 8'h49});
        check_beats("newline");
        check("newline_col", 32'(dut.col_q), 32'(17));

        // Clear during a stalled beat, with a same-cycle push that must be discarded
        do_reset;
        push(8'h58, 1'b0);
        wait_valid;
        check("clr_pre_data", 32'(out_data), 32'h58);
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_char = 8'h59;
        tick;
        clr_req = 1'b0;
        wr_en   = 1'b0;
        check("clr_post_valid", 32'(out_valid), 32'(1));
        check("clr_post_data",  32'(out_data),  32'h58);
        check("clr_post_busy",  32'(busy),      32'(1));
        push(8'h51, 1'b0);
        tick;
        check("clr_stall_data", 32'(out_data), 32'h58);
        check("clr_stall_rs",   32'(out_rs),   32'(1));
        out_ready = 1'b1;
        wait_idle;
        exp_q.push_back({1'b1, 8'h58});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h51});
        check_beats("clear");
        check("clear_col", 32'(dut.col_q), 32'(1));

        // Overflow: one beat stalled, 16 queued, 2 more dropped
        do_reset;
        push(8'h58, 1'b0);
        wait_valid;
        for (int i = 0; i < 16; i++) push(8'h66, 1'b0);
        check("ovf_full_16", 32'(full), 32'(1));
        check("ovf_pre",     32'(ovf),  32'(0));
        push(8'h67, 1'b0);
        push(8'h67, 1'b0);
        check("ovf_full_18", 32'(full), 32'(1));
        check("ovf_flag",    32'(ovf),  32'(ExpOvf));
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        check("ovf_clr_flag", 32'(ovf),  32'(0));
        check("ovf_clr_full", 32'(full), 32'(0));
        out_ready = 1'b1;
        wait_idle;
        exp_q.push_back({1'b1, 8'h58});
        exp_q.push_back({1'b0, 8'h01});
        check_beats("ovf_drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
